// File: rtl/array_op_scheduler_pkg.sv
// Shared definitions for the multiply/divide array scheduler: default widths,
// FSM state encoding, array mode encodings and the requester ID type.
package array_op_scheduler_pkg;

  localparam int DEF_NO_ROWS       = 10;
  localparam int DEF_NO_BITS_DIV   = 5;
  localparam int DEF_OUT_W         = 14;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Settle counter width; holds SETTLE_CYCLES-1 for the legal range 1..15.
  localparam int CNT_W = 4;

  // MUL_BAR encodings presented to the array.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Identifies which of the two requesters owns an operation.
  typedef logic req_id_t;

endpackage

// File: rtl/array_op_scheduler_rr_arb2.sv
// Two-input round-robin arbiter. A lone request always wins; when both
// request, the pointer decides. The pointer flips to the other requester
// after every accepted grant so contention alternates 0,1,0,1.
module rr_arb2
  import array_op_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output req_id_t    grant,
  output logic       grant_valid
);

  req_id_t ptr;

  // Grant selection: single requester wins outright, otherwise follow ptr.
  always_comb begin
    grant       = 1'b0;
    grant_valid = |req;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ptr;
      default: grant = 1'b0;
    endcase
  end

  // Pointer favours requester 0 out of reset and moves past each winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/array_op_scheduler.sv
// Sequencing and arbitration controller for the combinational mul/div array.
// Handshakes: a transfer happens on a rising clock edge where VALID and READY
// are both high. VALID, once raised, must not depend on READY; READY may
// depend on VALID. REQn_READY is combinational and only asserted in IDLE for
// the granted requester; RSP_* are held stable while RSP_VALID && !RSP_READY.
module array_op_scheduler
  import array_op_scheduler_pkg::*;
#(
  parameter int NO_ROWS       = DEF_NO_ROWS,
  parameter int NO_BITS_DIV   = DEF_NO_BITS_DIV,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   REQ0_VALID,
  output logic                   REQ0_READY,
  input  logic [NO_ROWS-1:0]     REQ0_Y,
  input  logic [NO_BITS_DIV-1:0] REQ0_X,
  input  logic                   REQ0_MUL_BAR,
  input  logic                   REQ1_VALID,
  output logic                   REQ1_READY,
  input  logic [NO_ROWS-1:0]     REQ1_Y,
  input  logic [NO_BITS_DIV-1:0] REQ1_X,
  input  logic                   REQ1_MUL_BAR,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   RSP_ID,
  output logic [OUT_W-1:0]       RSP_RESULT,
  output logic [NO_ROWS-1:0]     RSP_Q,
  output logic                   RSP_DIV0,
  output logic [NO_ROWS-1:0]     ARR_Y,
  output logic [NO_BITS_DIV-1:0] ARR_X,
  output logic                   ARR_MUL_BAR,
  input  logic [OUT_W-1:0]       ARR_REM_MUL_OUT,
  input  logic [NO_ROWS-1:0]     ARR_Q,
  output logic                   BUSY,
  output state_t                 DBG_STATE
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  req_id_t                grant_id;
  logic                   any_valid;
  logic                   accept;
  logic                   is_div0;
  logic                   settle_done;
  logic [NO_ROWS-1:0]     sel_y;
  logic [NO_BITS_DIV-1:0] sel_x;
  logic                   sel_mb;

  rr_arb2 u_arb (
    .clk         (CLK),
    .rst_n       (RST_N),
    .req         ({REQ1_VALID, REQ0_VALID}),
    .accept      (accept),
    .grant       (grant_id),
    .grant_valid (any_valid)
  );

  // Request-side decode: accept whenever IDLE and someone is valid.
  always_comb begin
    accept      = (state == ST_IDLE) && any_valid;
    REQ0_READY  = accept && (grant_id == 1'b0);
    REQ1_READY  = accept && (grant_id == 1'b1);
    sel_y       = grant_id ? REQ1_Y       : REQ0_Y;
    sel_x       = grant_id ? REQ1_X       : REQ0_X;
    sel_mb      = grant_id ? REQ1_MUL_BAR : REQ0_MUL_BAR;
    is_div0     = (sel_mb == MODE_DIV) && (sel_x == '0);
    settle_done = (state == ST_SETTLE) && (cnt == '0);
    RSP_VALID   = (state == ST_RESP);
    BUSY        = (state != ST_IDLE);
    DBG_STATE   = state;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; divide-by-zero skips the array entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = is_div0 ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:   if (RSP_READY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Settle counter: loaded on accept, counts down to the capture cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == ST_SETTLE) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand registers feed the array and only change on accept, so the
  // array inputs stay quiet between operations. Results captured at settle
  // end (or synthesised directly for divide-by-zero).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ARR_Y       <= '0;
      ARR_X       <= '0;
      ARR_MUL_BAR <= 1'b0;
      RSP_ID      <= 1'b0;
      RSP_RESULT  <= '0;
      RSP_Q       <= '0;
      RSP_DIV0    <= 1'b0;
    end else begin
      if (accept) begin
        ARR_Y       <= sel_y;
        ARR_X       <= sel_x;
        ARR_MUL_BAR <= sel_mb;
        RSP_ID      <= grant_id;
        if (is_div0) begin
          RSP_DIV0   <= 1'b1;
          RSP_Q      <= '1;
          RSP_RESULT <= '0;
        end
      end
      if (settle_done) begin
        RSP_DIV0 <= 1'b0;
        if (ARR_MUL_BAR == MODE_MUL) begin
          RSP_RESULT <= ARR_REM_MUL_OUT;
          RSP_Q      <= '0;
        end else begin
          RSP_RESULT <= {{(OUT_W-NO_BITS_DIV){1'b0}}, ARR_REM_MUL_OUT[NO_BITS_DIV-1:0]};
          RSP_Q      <= ARR_Q;
        end
      end
    end
  end

endmodule

// File: doc/array_op_scheduler.md
Name: array_op_scheduler

Overview:
- Sequencing and arbitration controller for the combinational multiply/divide array.
- The array has a 10-bit Y operand, a 5-bit X operand, a MUL_BAR mode select, a 14-bit REM_MUL_OUT result and a 10-bit Q result.
- The block shares the array between two requesters using round-robin arbitration, registers the operands onto the array, and waits a fixed settle time for the ripple path.
- It then captures the results and returns them over a valid/ready response channel; divide-by-zero is handled without using the array.

Parameters:
- NO_ROWS, 10: Y/dividend width and Q width.
- NO_BITS_DIV, 5: X/divisor width; the remainder occupies result bits [NO_BITS_DIV-1:0].
- OUT_W, 14: width of the array REM_MUL_OUT result.
- SETTLE_CYCLES, 4: cycles the operands are held before capture; legal range 1..15.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- REQ0_VALID  in  1  requester 0 has an operation
- REQ0_READY  out  1  requester 0 accepted this cycle
- REQ0_Y  in  NO_ROWS  multiplicand or dividend
- REQ0_X  in  NO_BITS_DIV  multiplier or divisor
- REQ0_MUL_BAR  in  1  0 = multiply, 1 = divide
- REQ1_VALID, REQ1_READY, REQ1_Y, REQ1_X, REQ1_MUL_BAR  same widths  requester 1
- RSP_VALID  out  1  result available
- RSP_READY  in  1  consumer takes the result
- RSP_ID  out  1  requester that owns the result
- RSP_RESULT  out  OUT_W  product, or remainder zero-extended
- RSP_Q  out  NO_ROWS  quotient; 0 for multiply
- RSP_DIV0  out  1  divide by zero flagged
- ARR_Y  out  NO_ROWS  registered operand to the array
- ARR_X  out  NO_BITS_DIV  registered operand to the array
- ARR_MUL_BAR  out  1  registered mode to the array
- ARR_REM_MUL_OUT  in  OUT_W  array result
- ARR_Q  in  NO_ROWS  array quotient
- BUSY  out  1  state is not IDLE

Behaviour:
- Reset values: every output register is 0; state is IDLE; the round-robin pointer favours requester 0. Reset is asynchronous and may arrive in any state; the in-flight operation is dropped with no response.
- States: IDLE, SETTLE, RESP.
- IDLE, arbitration:
  - If only one VALID is high, that requester is granted.
  - If both are high, the requester named by the pointer is granted.
  - READY is combinational: high only in IDLE and only for the granted requester. It may depend on VALID; VALID must never depend on READY.
- IDLE, accept (handshake at cycle T):
  - Operands and mode are latched into the ARR_* registers and the owner ID is latched.
  - The pointer moves to the other requester.
  - If MUL_BAR=1 and X=0: go to RESP at T+1 with RSP_DIV0=1, RSP_Q all ones, RSP_RESULT=0. The ARR_* registers are still updated.
  - Otherwise: load the counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - ARR_* stay stable throughout.
  - The counter decrements each cycle.
  - On the cycle the counter equals 0, capture the results and go to RESP:
    - Multiply: RSP_RESULT = ARR_REM_MUL_OUT, RSP_Q = 0.
    - Divide: RSP_RESULT = {zeros, ARR_REM_MUL_OUT[NO_BITS_DIV-1:0]}, RSP_Q = ARR_Q.
  - RSP_VALID rises at T+1+SETTLE_CYCLES.
- RESP:
  - RSP_* are held stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_VALID & RSP_READY, go to IDLE and clear RSP_VALID.
  - The next accept is possible one cycle after the response handshake at the earliest; there is no same-cycle overlap.
- When not in SETTLE, ARR_* keep the last operands, to reduce array toggling.
- Products at or above 2^OUT_W are truncated by the array; the scheduler passes the array output through unchanged.
- RSP_DIV0 is 0 for every non-zero-divisor operation.
- Throughput: one operation every SETTLE_CYCLES+2 cycles with RSP_READY tied high.

Decomposition:
- Shared package holds:
  - NO_ROWS, NO_BITS_DIV and OUT_W defaults.
  - The state enum.
  - MUL_BAR encodings MODE_MUL=0 and MODE_DIV=1.
  - The requester ID type.
- One natural sub-module: rr_arb2, a two-input round-robin arbiter with a pointer register that advances on accept.
- The counter and FSM stay in the top module.

Test Plan:
- Multiply, no contention: REQ0 Y=25, X=13, MUL_BAR=0, handshake at T.
  - ARR_Y=25 and ARR_X=13 at T+1.
  - RSP_VALID at T+5 with RSP_RESULT=325, RSP_Q=0, RSP_ID=0, RSP_DIV0=0.
- Divide: REQ1 Y=1000, X=7, MUL_BAR=1.
  - RSP_Q=142, RSP_RESULT=6, RSP_ID=1 after SETTLE_CYCLES+1 cycles.
- Divide by zero: REQ0 Y=55, X=0, MUL_BAR=1.
  - RSP_VALID at T+1 with RSP_DIV0=1, RSP_Q=1023, RSP_RESULT=0.
- Contention: REQ0 and REQ1 held valid continuously, RSP_READY=1.
  - Grant order is 0,1,0,1.
  - The READY pulses never overlap and are spaced 6 cycles apart.
- Backpressure: RSP_READY=0 for 10 cycles after RSP_VALID.
  - RSP_* stable, BUSY=1, both READY low.
  - On RSP_READY=1, IDLE follows next cycle.
- Reset mid-SETTLE: RST_N low during SETTLE.
  - All outputs 0 immediately; no response after release.
  - With both requesters valid, the first grant after release goes to requester 0.
